// File: rtl/multi_cycle_ctrl.sv
// ============================================================================
// multi_cycle_ctrl
// ----------------------------------------------------------------------------
// Control unit for a multi-cycle MIPS-like datapath. A five-state FSM
// (FETCH, DECODE, EXEC, MEM, WB) sequences each instruction. The datapath
// select lines are decoded combinationally from opcode/funct.
//
// Optional feature macro: MULTI_CYCLE_CTRL_PERF_CNT_EN
//   defined   -> 'retired' is a CNT_W-bit retired-instruction counter that
//                wraps around
//   undefined -> there is no counter register and 'retired' is tied to 0
//
// Parameters:
//   CNT_W        width of the retired-instruction counter
//
// Ports:
//   clk          sole clock, rising edge
//   rst          synchronous active-high reset
//   opcode       IR[31:26]
//   funct        IR[5:0]
//   zero         ALU zero flag (beq condition)
//   mem_ack      memory completes the outstanding request this cycle
//   mem_req      memory request strobe
//   mem_we       write qualifier for mem_req
//   mem_is_data  memory address select: 0 = PC, 1 = ALU result
//   ir_we        instruction register load
//   pc_we        PC load
//   pc_src       PC source: 00 PC+4, 01 branch target, 10 jump target
//   reg_we       GPR write strobe
//   alu_src      ALU B operand: 0 = register, 1 = immediate
//   gpr_dst      GPR destination: 0 = RT, 1 = RD
//   gpr_src      GPR write data: 00 ALU, 01 DMEM, 10 IMM
//   alu_op       000 add, 001 sub, 010 and, 011 or, 100 slt
//   illegal      one-cycle pulse on an undecodable instruction
//   retired      retired-instruction count
// ============================================================================
module multi_cycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_is_data,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_src,
    output logic             reg_we,
    output logic             alu_src,
    output logic             gpr_dst,
    output logic [1:0]       gpr_src,
    output logic [2:0]       alu_op,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    logic [2:0] r_state;
    logic [2:0] w_nextState;
    logic       w_retire;

    logic       w_legal;
    logic       w_isJ;
    logic       w_isBeq;
    logic       w_isLw;
    logic       w_isSw;
    logic       w_decAluSrc;
    logic       w_decGprDst;
    logic [1:0] w_decGprSrc;
    logic [2:0] w_decAluOp;

    // Instruction decoder. Produces the legality flag, the class flags the
    // FSM branches on, and the select values used from DECODE through WB.
    // An R-type with an unknown funct is illegal just like an unknown opcode.
    always_comb begin
        w_legal     = 1'b0;
        w_isJ       = 1'b0;
        w_isBeq     = 1'b0;
        w_isLw      = 1'b0;
        w_isSw      = 1'b0;
        w_decAluSrc = 1'b0;
        w_decGprDst = 1'b0;
        w_decGprSrc = 2'b00;
        w_decAluOp  = 3'b000;
        case (opcode)
            OP_RTYPE: begin
                w_decGprDst = 1'b1;
                w_legal     = 1'b1;
                case (funct)
                    6'h20:   w_decAluOp = 3'b000;
                    6'h22:   w_decAluOp = 3'b001;
                    6'h24:   w_decAluOp = 3'b010;
                    6'h25:   w_decAluOp = 3'b011;
                    6'h2A:   w_decAluOp = 3'b100;
                    default: w_legal    = 1'b0;
                endcase
            end
            OP_ADDI: begin
                w_legal     = 1'b1;
                w_decAluSrc = 1'b1;
            end
            OP_ORI: begin
                w_legal     = 1'b1;
                w_decAluSrc = 1'b1;
                w_decAluOp  = 3'b011;
            end
            OP_LUI: begin
                w_legal     = 1'b1;
                w_decAluSrc = 1'b1;
                w_decGprSrc = 2'b10;
            end
            OP_LW: begin
                w_legal     = 1'b1;
                w_isLw      = 1'b1;
                w_decAluSrc = 1'b1;
                w_decGprSrc = 2'b01;
            end
            OP_SW: begin
                w_legal     = 1'b1;
                w_isSw      = 1'b1;
                w_decAluSrc = 1'b1;
                w_decGprSrc = 2'b01;
            end
            OP_BEQ: begin
                w_legal    = 1'b1;
                w_isBeq    = 1'b1;
                w_decAluOp = 3'b001;
            end
            OP_J: begin
                w_legal = 1'b1;
                w_isJ   = 1'b1;
            end
            default: w_legal = 1'b0;
        endcase
    end

    // FSM next-state and output logic. While rst is high every output is
    // held at 0 so nothing leaves the controller during reset; the registered
    // state is forced to FETCH by the sequential block below. w_retire marks
    // each transition into FETCH that completes a legal instruction.
    always_comb begin
        w_nextState = r_state;
        w_retire    = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_is_data = 1'b0;
        ir_we       = 1'b0;
        pc_we       = 1'b0;
        pc_src      = 2'b00;
        reg_we      = 1'b0;
        alu_src     = 1'b0;
        gpr_dst     = 1'b0;
        gpr_src     = 2'b00;
        alu_op      = 3'b000;
        illegal     = 1'b0;
        if (!rst) begin
            if (r_state != S_FETCH && w_legal) begin
                alu_src = w_decAluSrc;
                gpr_dst = w_decGprDst;
                gpr_src = w_decGprSrc;
                alu_op  = w_decAluOp;
            end
            case (r_state)
                S_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ack) begin
                        ir_we       = 1'b1;
                        pc_we       = 1'b1;
                        w_nextState = S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (!w_legal) begin
                        illegal     = 1'b1;
                        w_nextState = S_FETCH;
                    end else if (w_isJ) begin
                        pc_we       = 1'b1;
                        pc_src      = 2'b10;
                        w_retire    = 1'b1;
                        w_nextState = S_FETCH;
                    end else begin
                        w_nextState = S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (w_isBeq) begin
                        pc_we       = zero;
                        pc_src      = 2'b01;
                        w_retire    = 1'b1;
                        w_nextState = S_FETCH;
                    end else if (w_isLw || w_isSw) begin
                        w_nextState = S_MEM;
                    end else begin
                        w_nextState = S_WB;
                    end
                end
                S_MEM: begin
                    mem_req     = 1'b1;
                    mem_is_data = 1'b1;
                    mem_we      = w_isSw;
                    if (mem_ack) begin
                        if (w_isSw) begin
                            w_retire    = 1'b1;
                            w_nextState = S_FETCH;
                        end else begin
                            w_nextState = S_WB;
                        end
                    end
                end
                S_WB: begin
                    reg_we      = 1'b1;
                    w_retire    = 1'b1;
                    w_nextState = S_FETCH;
                end
                default: w_nextState = S_FETCH;
            endcase
        end
    end

    // State register. Reset wins over any pending transition, including a
    // coincident mem_ack, so an interrupted instruction simply restarts at
    // FETCH.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_nextState;
        end
    end

`ifdef MULTI_CYCLE_CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] r_retired;

    // Retired-instruction counter; wraps naturally at 2^CNT_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_retired <= '0;
        end else if (w_retire) begin
            r_retired <= r_retired + CNT_W'(1);
        end
    end

    assign retired = r_retired;
`else
    logic w_unusedRetire;

    // Counter not built: the retire event has no consumer.
    assign w_unusedRetire = w_retire;
    assign retired        = '0;
`endif

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// ============================================================================
// tb_multi_cycle_ctrl
// ----------------------------------------------------------------------------
// Directed testbench for multi_cycle_ctrl. Each step drives the inputs on the
// falling clock edge, lets the combinational outputs settle, and compares the
// whole output vector against a hand-computed constant. Output vector field
// order (16 bits):
//   mem_req _ mem_we _ mem_is_data _ ir_we _ pc_we _ pc_src[1:0] _ reg_we _
//   alu_src _ gpr_dst _ gpr_src[1:0] _ alu_op[2:0] _ illegal
// ============================================================================
module tb_multi_cycle_ctrl;

    localparam int CNT_W = 32;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BAD   = 6'h3F;

    localparam logic [15:0] V_ZERO      = 16'b0_0_0_0_0_00_0_0_0_00_000_0;
    localparam logic [15:0] V_FETCH     = 16'b1_0_0_0_0_00_0_0_0_00_000_0;
    localparam logic [15:0] V_FETCH_ACK = 16'b1_0_0_1_1_00_0_0_0_00_000_0;
    localparam logic [15:0] V_ADDI      = 16'b0_0_0_0_0_00_0_1_0_00_000_0;
    localparam logic [15:0] V_ADDI_WB   = 16'b0_0_0_0_0_00_1_1_0_00_000_0;
    localparam logic [15:0] V_LDST      = 16'b0_0_0_0_0_00_0_1_0_01_000_0;
    localparam logic [15:0] V_LW_MEM    = 16'b1_0_1_0_0_00_0_1_0_01_000_0;
    localparam logic [15:0] V_LW_WB     = 16'b0_0_0_0_0_00_1_1_0_01_000_0;
    localparam logic [15:0] V_SW_MEM    = 16'b1_1_1_0_0_00_0_1_0_01_000_0;
    localparam logic [15:0] V_BEQ       = 16'b0_0_0_0_0_00_0_0_0_00_001_0;
    localparam logic [15:0] V_BEQ_TAKE  = 16'b0_0_0_0_1_01_0_0_0_00_001_0;
    localparam logic [15:0] V_BEQ_NOT   = 16'b0_0_0_0_0_01_0_0_0_00_001_0;
    localparam logic [15:0] V_ILLEGAL   = 16'b0_0_0_0_0_00_0_0_0_00_000_1;
    localparam logic [15:0] V_JUMP      = 16'b0_0_0_0_1_10_0_0_0_00_000_0;
    localparam logic [15:0] V_SUB       = 16'b0_0_0_0_0_00_0_0_1_00_001_0;
    localparam logic [15:0] V_SUB_WB    = 16'b0_0_0_0_0_00_1_0_1_00_001_0;
    localparam logic [15:0] V_ORI       = 16'b0_0_0_0_0_00_0_1_0_00_011_0;
    localparam logic [15:0] V_ORI_WB    = 16'b0_0_0_0_0_00_1_1_0_00_011_0;
    localparam logic [15:0] V_LUI       = 16'b0_0_0_0_0_00_0_1_0_10_000_0;
    localparam logic [15:0] V_LUI_WB    = 16'b0_0_0_0_0_00_1_1_0_10_000_0;

    logic             clk;
    logic             rst;
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic             zero;
    logic             mem_ack;
    logic             mem_req;
    logic             mem_we;
    logic             mem_is_data;
    logic             ir_we;
    logic             pc_we;
    logic [1:0]       pc_src;
    logic             reg_we;
    logic             alu_src;
    logic             gpr_dst;
    logic [1:0]       gpr_src;
    logic [2:0]       alu_op;
    logic             illegal;
    logic [CNT_W-1:0] retired;

    int nCompared;
    int nMismatched;

    multi_cycle_ctrl #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .opcode      (opcode),
        .funct       (funct),
        .zero        (zero),
        .mem_ack     (mem_ack),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_is_data (mem_is_data),
        .ir_we       (ir_we),
        .pc_we       (pc_we),
        .pc_src      (pc_src),
        .reg_we      (reg_we),
        .alu_src     (alu_src),
        .gpr_dst     (gpr_dst),
        .gpr_src     (gpr_src),
        .alu_op      (alu_op),
        .illegal     (illegal),
        .retired     (retired)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected retired count: the counter only exists when the performance
    // counter macro is defined; otherwise the output is always 0.
    function automatic logic [CNT_W-1:0] expRet(input int n);
`ifdef MULTI_CYCLE_CTRL_PERF_CNT_EN
        return CNT_W'(n);
`else
        return (n == 0) ? '0 : '0;
`endif
    endfunction

    // Drive one cycle's inputs on the falling edge, then wait for the
    // combinational outputs to settle before any check.
    task automatic applyStimulus(input logic r, input logic [5:0] op,
                                 input logic [5:0] fn, input logic z,
                                 input logic ack);
        @(negedge clk);
        rst     = r;
        opcode  = op;
        funct   = fn;
        zero    = z;
        mem_ack = ack;
        #1;
    endtask

    // Compare the full output vector with the expected constant.
    task automatic checkOutput(input string tag, input logic [15:0] expVec);
        logic [15:0] obsVec;
        obsVec = {mem_req, mem_we, mem_is_data, ir_we, pc_we, pc_src,
                  reg_we, alu_src, gpr_dst, gpr_src, alu_op, illegal};
        nCompared++;
        assert (obsVec === expVec)
        else begin
            nMismatched++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, obsVec, expVec);
        end
    endtask

    // Compare the retired counter with the expected count.
    task automatic checkRetired(input string tag, input int n);
        logic [CNT_W-1:0] expCnt;
        expCnt = expRet(n);
        nCompared++;
        assert (retired === expCnt)
        else begin
            nMismatched++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, retired, expCnt);
        end
    endtask

    // Directed sequence: one instruction class after another, ending with
    // a reset that lands on a store's data access together with mem_ack.
    initial begin
        nCompared   = 0;
        nMismatched = 0;
        rst         = 1'b1;
        opcode      = 6'h00;
        funct       = 6'h00;
        zero        = 1'b0;
        mem_ack     = 1'b0;

        applyStimulus(1'b1, OP_RTYPE, 6'h00, 1'b0, 1'b0);
        checkOutput("reset_hold", V_ZERO);
        checkRetired("reset_retired", 0);
        applyStimulus(1'b1, OP_RTYPE, 6'h00, 1'b0, 1'b1);
        checkOutput("reset_hold_ack", V_ZERO);

        // addi with mem_ack high every cycle
        applyStimulus(1'b0, OP_ADDI, 6'h00, 1'b0, 1'b1);
        checkOutput("addi_fetch", V_FETCH_ACK);
        applyStimulus(1'b0, OP_ADDI, 6'h00, 1'b0, 1'b1);
        checkOutput("addi_decode", V_ADDI);
        applyStimulus(1'b0, OP_ADDI, 6'h00, 1'b0, 1'b1);
        checkOutput("addi_exec", V_ADDI);
        applyStimulus(1'b0, OP_ADDI, 6'h00, 1'b0, 1'b1);
        checkOutput("addi_wb", V_ADDI_WB);

        // lw with data ack delayed three cycles
        applyStimulus(1'b0, OP_LW, 6'h00, 1'b0, 1'b1);
        checkOutput("lw_fetch", V_FETCH_ACK);
        checkRetired("retired_after_addi", 1);
        applyStimulus(1'b0, OP_LW, 6'h00, 1'b0, 1'b0);
        checkOutput("lw_decode", V_LDST);
        applyStimulus(1'b0, OP_LW, 6'h00, 1'b0, 1'b0);
        checkOutput("lw_exec", V_LDST);
        applyStimulus(1'b0, OP_LW, 6'h00, 1'b0, 1'b0);
        checkOutput("lw_mem_wait1", V_LW_MEM);
        applyStimulus(1'b0, OP_LW, 6'h00, 1'b0, 1'b0);
        checkOutput("lw_mem_wait2", V_LW_MEM);
        applyStimulus(1'b0, OP_LW, 6'h00, 1'b0, 1'b0);
        checkOutput("lw_mem_wait3", V_LW_MEM);
        applyStimulus(1'b0, OP_LW, 6'h00, 1'b0, 1'b1);
        checkOutput("lw_mem_ack", V_LW_MEM);
        applyStimulus(1'b0, OP_LW, 6'h00, 1'b0, 1'b0);
        checkOutput("lw_wb", V_LW_WB);

        // beq taken (zero=1)
        applyStimulus(1'b0, OP_BEQ, 6'h00, 1'b1, 1'b1);
        checkOutput("beq1_fetch", V_FETCH_ACK);
        checkRetired("retired_after_lw", 2);
        applyStimulus(1'b0, OP_BEQ, 6'h00, 1'b1, 1'b0);
        checkOutput("beq1_decode", V_BEQ);
        applyStimulus(1'b0, OP_BEQ, 6'h00, 1'b1, 1'b0);
        checkOutput("beq1_exec_taken", V_BEQ_TAKE);

        // beq not taken (zero=0), fetch waits one cycle first
        applyStimulus(1'b0, OP_BEQ, 6'h00, 1'b0, 1'b0);
        checkOutput("beq2_fetch_wait", V_FETCH);
        checkRetired("retired_after_beq1", 3);
        applyStimulus(1'b0, OP_BEQ, 6'h00, 1'b0, 1'b1);
        checkOutput("beq2_fetch", V_FETCH_ACK);
        applyStimulus(1'b0, OP_BEQ, 6'h00, 1'b0, 1'b0);
        checkOutput("beq2_decode", V_BEQ);
        applyStimulus(1'b0, OP_BEQ, 6'h00, 1'b0, 1'b0);
        checkOutput("beq2_exec_not_taken", V_BEQ_NOT);

        // unknown opcode, then R-type with unknown funct
        applyStimulus(1'b0, OP_BAD, 6'h20, 1'b0, 1'b1);
        checkOutput("bad_op_fetch", V_FETCH_ACK);
        checkRetired("retired_after_beq2", 4);
        applyStimulus(1'b0, OP_BAD, 6'h20, 1'b0, 1'b0);
        checkOutput("bad_op_decode", V_ILLEGAL);
        applyStimulus(1'b0, OP_RTYPE, 6'h00, 1'b0, 1'b1);
        checkOutput("bad_funct_fetch", V_FETCH_ACK);
        checkRetired("retired_after_bad_op", 4);
        applyStimulus(1'b0, OP_RTYPE, 6'h00, 1'b0, 1'b0);
        checkOutput("bad_funct_decode", V_ILLEGAL);

        // j
        applyStimulus(1'b0, OP_J, 6'h00, 1'b0, 1'b1);
        checkOutput("j_fetch", V_FETCH_ACK);
        checkRetired("retired_after_bad_funct", 4);
        applyStimulus(1'b0, OP_J, 6'h00, 1'b0, 1'b1);
        checkOutput("j_decode", V_JUMP);

        // R-type sub
        applyStimulus(1'b0, OP_RTYPE, 6'h22, 1'b0, 1'b1);
        checkOutput("sub_fetch", V_FETCH_ACK);
        checkRetired("retired_after_j", 5);
        applyStimulus(1'b0, OP_RTYPE, 6'h22, 1'b0, 1'b0);
        checkOutput("sub_decode", V_SUB);
        applyStimulus(1'b0, OP_RTYPE, 6'h22, 1'b0, 1'b0);
        checkOutput("sub_exec", V_SUB);
        applyStimulus(1'b0, OP_RTYPE, 6'h22, 1'b0, 1'b0);
        checkOutput("sub_wb", V_SUB_WB);

        // ori
        applyStimulus(1'b0, OP_ORI, 6'h00, 1'b0, 1'b1);
        checkOutput("ori_fetch", V_FETCH_ACK);
        checkRetired("retired_after_sub", 6);
        applyStimulus(1'b0, OP_ORI, 6'h00, 1'b0, 1'b0);
        checkOutput("ori_decode", V_ORI);
        applyStimulus(1'b0, OP_ORI, 6'h00, 1'b0, 1'b0);
        checkOutput("ori_exec", V_ORI);
        applyStimulus(1'b0, OP_ORI, 6'h00, 1'b0, 1'b0);
        checkOutput("ori_wb", V_ORI_WB);

        // lui
        applyStimulus(1'b0, OP_LUI, 6'h00, 1'b0, 1'b1);
        checkOutput("lui_fetch", V_FETCH_ACK);
        checkRetired("retired_after_ori", 7);
        applyStimulus(1'b0, OP_LUI, 6'h00, 1'b0, 1'b0);
        checkOutput("lui_decode", V_LUI);
        applyStimulus(1'b0, OP_LUI, 6'h00, 1'b0, 1'b0);
        checkOutput("lui_exec", V_LUI);
        applyStimulus(1'b0, OP_LUI, 6'h00, 1'b0, 1'b0);
        checkOutput("lui_wb", V_LUI_WB);

        // sw interrupted by reset during its data wait, with mem_ack coincident
        applyStimulus(1'b0, OP_SW, 6'h00, 1'b0, 1'b1);
        checkOutput("sw1_fetch", V_FETCH_ACK);
        checkRetired("retired_after_lui", 8);
        applyStimulus(1'b0, OP_SW, 6'h00, 1'b0, 1'b0);
        checkOutput("sw1_decode", V_LDST);
        applyStimulus(1'b0, OP_SW, 6'h00, 1'b0, 1'b0);
        checkOutput("sw1_exec", V_LDST);
        applyStimulus(1'b0, OP_SW, 6'h00, 1'b0, 1'b0);
        checkOutput("sw1_mem_wait", V_SW_MEM);
        applyStimulus(1'b1, OP_SW, 6'h00, 1'b0, 1'b1);
        checkOutput("sw1_reset_with_ack", V_ZERO);
        applyStimulus(1'b0, OP_SW, 6'h00, 1'b0, 1'b0);
        checkOutput("after_reset_fetch", V_FETCH);
        checkRetired("retired_after_reset", 0);

        // sw completing normally with zero-wait memory
        applyStimulus(1'b0, OP_SW, 6'h00, 1'b0, 1'b1);
        checkOutput("sw2_fetch", V_FETCH_ACK);
        applyStimulus(1'b0, OP_SW, 6'h00, 1'b0, 1'b1);
        checkOutput("sw2_decode", V_LDST);
        applyStimulus(1'b0, OP_SW, 6'h00, 1'b0, 1'b1);
        checkOutput("sw2_exec", V_LDST);
        applyStimulus(1'b0, OP_SW, 6'h00, 1'b0, 1'b1);
        checkOutput("sw2_mem_ack", V_SW_MEM);
        applyStimulus(1'b0, OP_ADDI, 6'h00, 1'b0, 1'b0);
        checkOutput("sw2_back_to_fetch", V_FETCH);
        checkRetired("retired_after_sw2", 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
